// File: rtl/spi_xfer_sequencer.sv
// Multi-byte SPI transfer sequencer: host register slave plus a bus master that drives the
// byte-level SPI peripheral. Optional irq output and CTRL.IRQ_EN under SPI_XFER_SEQUENCER_IRQ_EN.
module spi_xfer_sequencer #(
  parameter logic [31:0] ADDR     = 32'hd100,
  parameter logic [31:0] SPI_ADDR = 32'hd000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wen,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        active,
`ifdef SPI_XFER_SEQUENCER_IRQ_EN
  output logic        irq,
`endif
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  output logic        m_wen,
  output logic        m_ren,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);
  typedef enum logic [3:0] {
    IDLE, WR_DATA, WR_START, POLL_FIN, RD_DATA, WR_STOP, POLL_IDLE, NEXT, WR_CSOFF, FIN
  } state_t;
  state_t state;

  logic [31:0]     prev_addr, aw, bmask;
  logic            hit_ctrl, hit_div, hit_stat, hit_buf0, hit_buf1;
  logic [7:0][7:0] tx, rx;
  logic [29:0]     div;
  logic [2:0]      len;
  logic            hold_cs, irq_en, busy, done, wr_ok, go;
  logic [3:0]      cnt;
  logic            unused_ok;

  assign aw       = {addr[31:2], 2'b00};
  assign hit_ctrl = aw == ADDR;
  assign hit_div  = aw == ADDR + 32'h4;
  assign hit_stat = aw == ADDR + 32'h8;
  assign hit_buf0 = aw == ADDR + 32'h10;
  assign hit_buf1 = aw == ADDR + 32'h14;
  assign active   = hit_ctrl | hit_div | hit_stat | hit_buf0 | hit_buf1;
  assign ready    = addr == prev_addr;
  assign wr_ok    = wen & ~busy;
  assign go       = wr_ok & hit_ctrl & wmask[0] & wdata[0];
  assign bmask    = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign m_wmask  = 4'hF;
  assign unused_ok = ^{ren, m_rdata[31:16], m_rdata[7:2], bmask[31:30]};

  always_comb begin
    rdata = '0;
    if (hit_ctrl)      rdata = {24'b0, irq_en, len, 2'b0, hold_cs, 1'b0};
    else if (hit_div)  rdata = {2'b0, div};
    else if (hit_stat) rdata = {24'b0, cnt, 2'b0, done, busy};
    else if (hit_buf0) rdata = rx[3:0];
    else if (hit_buf1) rdata = rx[7:4];
  end

  // Host-writable configuration; frozen while a transfer is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_addr <= '0;
      len       <= '0;
      hold_cs   <= 1'b0;
      div       <= '0;
      tx        <= '0;
    end else begin
      prev_addr <= addr;
      if (wr_ok) begin
        if (hit_ctrl && wmask[0]) begin
          len     <= wdata[6:4];
          hold_cs <= wdata[1];
        end
        if (hit_div) div <= (div & ~bmask[29:0]) | (wdata[29:0] & bmask[29:0]);
        for (int b = 0; b < 4; b++) begin
          if (hit_buf0 && wmask[b]) tx[b]   <= wdata[8*b +: 8];
          if (hit_buf1 && wmask[b]) tx[b+4] <= wdata[8*b +: 8];
        end
      end
    end
  end

`ifdef SPI_XFER_SEQUENCER_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr_ok && hit_ctrl && wmask[0]) irq_en <= wdata[7];
      irq <= go ? 1'b0 : (done & irq_en);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  // Each state owns one master access; the next access is set up on the m_ready cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      rx      <= '0;
      m_addr  <= SPI_ADDR;
      m_wdata <= '0;
      m_wen   <= 1'b0;
      m_ren   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          busy    <= 1'b1;
          done    <= 1'b0;
          cnt     <= '0;
          state   <= WR_DATA;
          m_addr  <= SPI_ADDR + 32'h8;
          m_wdata <= {24'b0, tx[0]};
          m_wen   <= 1'b1;
        end
        WR_DATA: if (m_ready) begin
          state   <= WR_START;
          m_addr  <= SPI_ADDR + 32'h4;
          m_wdata <= {div, 2'b11};
        end
        WR_START: if (m_ready) begin
          state  <= POLL_FIN;
          m_addr <= SPI_ADDR;
          m_wen  <= 1'b0;
          m_ren  <= 1'b1;
        end
        POLL_FIN: if (m_ready && m_rdata[0]) begin
          state  <= RD_DATA;
          m_addr <= SPI_ADDR + 32'h8;
        end
        RD_DATA: if (m_ready) begin
          rx[cnt[2:0]] <= m_rdata[15:8];
          state   <= WR_STOP;
          m_addr  <= SPI_ADDR + 32'h4;
          m_wdata <= {div, 2'b10};
          m_ren   <= 1'b0;
          m_wen   <= 1'b1;
        end
        WR_STOP: if (m_ready) begin
          state  <= POLL_IDLE;
          m_addr <= SPI_ADDR;
          m_wen  <= 1'b0;
          m_ren  <= 1'b1;
        end
        POLL_IDLE: if (m_ready && !m_rdata[1]) begin
          state <= NEXT;
          m_ren <= 1'b0;
        end
        NEXT: begin
          cnt <= cnt + 4'd1;
          if (cnt[2:0] == len) begin
            if (hold_cs) state <= FIN;
            else begin
              state   <= WR_CSOFF;
              m_addr  <= SPI_ADDR + 32'h4;
              m_wdata <= {div, 2'b00};
              m_wen   <= 1'b1;
            end
          end else begin
            state   <= WR_DATA;
            m_addr  <= SPI_ADDR + 32'h8;
            m_wdata <= {24'b0, tx[cnt[2:0] + 3'd1]};
            m_wen   <= 1'b1;
          end
        end
        WR_CSOFF: if (m_ready) begin
          state <= FIN;
          m_wen <= 1'b0;
        end
        FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
